// File: rtl/id_decode_sb_pkg.sv
// Shared opcode map, class codes and per-opcode decode attributes for the
// decode stage and its scoreboard.
package id_pkg;

  localparam int OPC_BITS = 5;

  localparam logic [OPC_BITS-1:0] OP_MOV            = 5'b00000;
  localparam logic [OPC_BITS-1:0] OP_LD             = 5'b00001;
  localparam logic [OPC_BITS-1:0] OP_ADD            = 5'b00011;
  localparam logic [OPC_BITS-1:0] OP_SUB            = 5'b00100;
  localparam logic [OPC_BITS-1:0] OP_AND            = 5'b00101;
  localparam logic [OPC_BITS-1:0] OP_OR             = 5'b00110;
  localparam logic [OPC_BITS-1:0] OP_NOT            = 5'b00111;
  localparam logic [OPC_BITS-1:0] OP_JMP            = 5'b01000;
  localparam logic [OPC_BITS-1:0] OP_NOP            = 5'b01001;
  localparam logic [OPC_BITS-1:0] OP_OB_CHECK       = 5'b01010;
  localparam logic [OPC_BITS-1:0] OP_MOVE_FORWARD   = 5'b01011;
  localparam logic [OPC_BITS-1:0] OP_MOVE_BACKWARD  = 5'b01100;
  localparam logic [OPC_BITS-1:0] OP_MOVE_LEFT      = 5'b01101;
  localparam logic [OPC_BITS-1:0] OP_MOVE_RIGHT     = 5'b01110;
  localparam logic [OPC_BITS-1:0] OP_VELOCITY_GUARD = 5'b01111;
  localparam logic [OPC_BITS-1:0] OP_CMP            = 5'b10000;
  localparam logic [OPC_BITS-1:0] OP_MULT           = 5'b10001;
  localparam logic [OPC_BITS-1:0] OP_DIVSION        = 5'b10010;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_MEM    = 3'd1;
  localparam logic [2:0] CLS_CAR    = 3'd2;
  localparam logic [2:0] CLS_SENSOR = 3'd3;
  localparam logic [2:0] CLS_CTRL   = 3'd4;

  typedef struct packed {
    logic       legal;
    logic       nop;
    logic [2:0] cls;
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       uses_imm;
  } decode_t;

  function automatic decode_t decode_op(input logic [OPC_BITS-1:0] opc);
    decode_t d;
    d = '0;
    d.legal = 1'b1;
    case (opc)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_CMP, OP_MULT, OP_DIVSION: begin
        d.cls       = CLS_ALU;
        d.writes_rd = 1'b1;
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
      end
      OP_LD: begin
        d.cls       = CLS_MEM;
        d.writes_rd = 1'b1;
        d.uses_rs1  = 1'b1;
        d.uses_imm  = 1'b1;
      end
      OP_MOVE_FORWARD, OP_MOVE_BACKWARD, OP_MOVE_LEFT, OP_MOVE_RIGHT: begin
        d.cls = CLS_CAR;
      end
      OP_OB_CHECK, OP_VELOCITY_GUARD: begin
        d.cls       = CLS_SENSOR;
        d.writes_rd = 1'b1;
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
      end
      OP_JMP: begin
        d.cls      = CLS_CTRL;
        d.uses_rs1 = 1'b1;
        d.uses_imm = 1'b1;
      end
      OP_NOP:  d.nop = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic int pkt_width(input int data_w, input int reg_aw, input int opc_w);
    return 3 + opc_w + reg_aw + 2 * data_w;
  endfunction

endpackage

// File: rtl/id_decode_sb_scoreboard.sv
// Pending-write tracker: one busy bit per register, issue-set beats
// writeback-clear, and a hazard flag for the instruction being decoded.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              chk_rs1,
  input  logic              chk_rs2,
  input  logic              chk_rd,
  output logic [NREG-1:0]   busy_mask,
  output logic              hazard
);

  logic [NREG-1:0] busy;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            rd_pend;

  // A register being written back this cycle no longer blocks anyone.
  assign rs1_pend = busy[rs1] && !(clr_en && clr_addr == rs1);
  assign rs2_pend = busy[rs2] && !(clr_en && clr_addr == rs2);
  assign rd_pend  = busy[rd]  && !(clr_en && clr_addr == rd);

  assign hazard = (chk_rs1 && rs1_pend) || (chk_rs2 && rs2_pend) || (chk_rd && rd_pend);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  assign busy_mask = busy;

endmodule

// File: rtl/id_decode_sb.sv
// Decode stage: register file with writeback bypass, hazard stall via the
// scoreboard, and a single output register held under FIFO backpressure.
module id_decode_sb
  import id_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 16,
  parameter  int OPC_W  = 5,
  localparam int REG_AW = $clog2(NREG),
  localparam int PKT_W  = pkt_width(DATA_W, REG_AW, OPC_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] WB_data,
  input  logic [REG_AW-1:0] WB_reg_addr,
  input  logic              WB_reg_write,
  output logic [PKT_W-1:0]  fifo_data,
  output logic              fifo_wr_en,
  input  logic              fifo_wr_ready,
  output logic [NREG-1:0]   busy_mask,
  output logic              illegal_op
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [14:0]       imm;
  decode_t           dec;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic hazard;
  logic stall;
  logic accept;
  logic issue;

  assign opcode = instruction[31 -: OPC_W];
  assign rd     = instruction[26 -: REG_AW];
  assign rs1    = instruction[22 -: REG_AW];
  assign rs2    = instruction[18 -: REG_AW];
  assign imm    = instruction[14:0];
  assign dec    = decode_op(opcode);

  assign rs1_val = (WB_reg_write && WB_reg_addr == rs1) ? WB_data : regs[rs1];
  assign rs2_val = (WB_reg_write && WB_reg_addr == rs2) ? WB_data : regs[rs2];
  assign imm_ext = DATA_W'(imm);

  assign op_a = dec.uses_rs1 ? rs1_val : '0;
  assign op_b = dec.uses_rs2 ? rs2_val : (dec.uses_imm ? imm_ext : '0);

  // Only legal, non-NOP instructions can be held back; NOPs and undefined
  // opcodes are always consumed once the output side has room.
  assign stall       = instr_valid && dec.legal && !dec.nop && hazard;
  assign instr_ready = !stall && (!fifo_wr_en || fifo_wr_ready);
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && dec.legal && !dec.nop;

  id_scoreboard #(
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (issue && dec.writes_rd),
    .set_addr  (rd),
    .clr_en    (WB_reg_write),
    .clr_addr  (WB_reg_addr),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .chk_rs1   (dec.uses_rs1),
    .chk_rs2   (dec.uses_rs2),
    .chk_rd    (dec.writes_rd),
    .busy_mask (busy_mask),
    .hazard    (hazard)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WB_reg_write) begin
      regs[WB_reg_addr] <= WB_data;
    end
  end

  // Output register: a new packet may only land when the old one is gone or
  // leaving this cycle, which instr_ready already guarantees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && !dec.legal;
      if (issue) begin
        fifo_wr_en <= 1'b1;
        fifo_data  <= {dec.cls, opcode, rd, op_a, op_b};
      end else if (fifo_wr_ready) begin
        fifo_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: doc/id_decode_sb.md
# id_decode_sb

Parametrised decode stage with a register file, a RAW/WAW scoreboard and an elastic output. It sits between fetch and the execute-side FIFO of the async CPU. It accepts instructions on a valid/ready handshake and reads operands, bypassing same-cycle writeback. It stalls on register hazards and emits one decoded packet per instruction into the downstream FIFO, holding it under backpressure.

## Interface
Parameters:
- DATA_W, 16, register/operand width
- NREG, 16, register count; REG_AW = $clog2(NREG), 4 at default
- OPC_W, 5, opcode width
- PKT_W, derived, 3+OPC_W+REG_AW+2*DATA_W (44 at defaults)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- instruction  in  32  [31:27] opcode, [26:23] rd, [22:19] rs1, [18:15] rs2, [14:0] imm
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage accepts this cycle
- WB_data  in  DATA_W  writeback value
- WB_reg_addr  in  REG_AW  writeback register
- WB_reg_write  in  1  writeback strobe
- fifo_data  out  PKT_W  {class[2:0], opcode, rd, op_a, op_b}
- fifo_wr_en  out  1  packet valid; held until taken
- fifo_wr_ready  in  1  FIFO can accept
- busy_mask  out  NREG  scoreboard state, bit i = write to ri pending
- illegal_op  out  1  one-cycle pulse on acceptance of an undefined opcode

## Operation
- Classes: ALU=0 (MOV 00000, ADD 00011, SUB 00100, AND 00101, OR 00110, NOT 00111, CMP 10000, MULT 10001, DIVSION 10010); MEM=1 (LD 00001); CAR=2 (01011–01110); SENSOR=3 (OB_CHECK 01010, VELOCITY_GUARD 01111); CTRL=4 (JMP 01000).
- Writers (set busy[rd]): ALU, MEM and SENSOR classes. CAR and CTRL do not write rd.
- Operand sources:
  - op_a = reg[rs1].
  - op_b = reg[rs2] for ALU and SENSOR.
  - op_b = zero-extended imm for MEM and CTRL.
  - op_a/op_b = 0 for CAR.
- Bypass: if WB_reg_write and WB_reg_addr matches a read address in the same cycle, the operand is WB_data.
- Writeback: reg[WB_reg_addr] <= WB_data and busy[WB_reg_addr] <= 0 at the clock edge.
- Hazard stall conditions:
  - RAW: a used source register is busy and not being written back this cycle.
  - WAW: a writer's rd is busy and not being written back this cycle.
- Handshake: instr_ready = !stall && (!fifo_wr_en || fifo_wr_ready). Accept = instr_valid && instr_ready.
- Emission on accept:
  - Legal non-NOP opcode: packet loaded into the output register.
  - NOP (01001): consumed, no packet.
  - Undefined opcode: consumed, no packet, illegal_op = 1 for one cycle, scoreboard untouched.
- Simultaneous issue setting busy[r] and writeback clearing busy[r]: set wins.
- Output: a FIFO write occurs on fifo_wr_en && fifo_wr_ready. fifo_data is stable while fifo_wr_en is high and fifo_wr_ready is low.

## Timing
- Reset (async): all registers 0, busy_mask 0, fifo_wr_en 0, fifo_data 0, illegal_op 0. instr_ready is 1 once reset deasserts. Reset mid-stall or mid-hold discards the held packet and all pending busy bits.
- Latency: packet on fifo_data/fifo_wr_en one cycle after the accepting edge. Throughput is 1 instruction/cycle when the FIFO is ready and there are no hazards.
- Operands are sampled at the accepting edge. Later writebacks do not alter a held packet.
- A stalled instruction issues in the cycle its blocking register is written back, via the bypass. It appears on the FIFO the cycle after.
- instr_ready depends combinationally on fifo_wr_ready, instr and WB inputs. The decode is single-stage; there is no skid buffer.

## Structure
- Package id_pkg holds:
  - opcode localparams (names as above)
  - class codes
  - a writes_rd/uses_rs2/uses_imm decode function
  - the PKT_W expression
- Sub-module id_scoreboard (NREG, REG_AW) owns the busy vector, set/clear priority and the hazard-check outputs.
- The register file, bypass and output register stay in the top module.

## Test plan
- Reset, WB r1=ABCD, r2=1234, then ADD r3,r1,r2 → next cycle fifo_wr_en=1, fifo_data={0,00011,3,ABCD,1234}, busy_mask=0x0008.
- ADD r3,r1,r2 then SUB r4,r3,r1 → SUB held (instr_ready=0) until WB r3=5555; it issues in the WB cycle with op_a=5555.
- fifo_wr_ready=0 for 3 cycles after an issue → fifo_data unchanged, instr_ready=0. A write occurs on the first ready cycle, and the next instruction is accepted in that same cycle.
- NOP then opcode 11111 → no FIFO write, illegal_op pulses exactly once, busy_mask unchanged.
- MOVE_LEFT rd=4 and JMP imm=0x0123 → class 2 with zero operands, class 4 with op_b=0123. Neither sets a busy bit.
- Reset asserted while a packet is held and busy_mask=0x0030 → fifo_wr_en, busy_mask and all registers read 0 immediately.
